// File: rtl/reg_file_sb_pkg.sv
// reg_file_pkg: shared constants and helpers for the reg_file_sb slice.
//   ZERO_IDX  - index of the hard-wired zero register
//   idx_w(n)  - index width for an n-entry register file
//   slice_lo  - low bit of field p in a packed multi-port bus of w-bit fields
package reg_file_pkg;

  localparam int unsigned ZERO_IDX = 0;

  function automatic int unsigned idx_w(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned slice_lo(input int unsigned p, input int unsigned w);
    return p * w;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: decode/write-back bus of the scoreboarded register file.
//   master: drives read request, reservation, write-back and flush;
//           receives reg_stall, rs_valid, rs_data.
//   slave : the register file itself.
interface reg_file_sb_if
  import reg_file_pkg::*;
#(
  parameter int unsigned LEN      = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RP   = 2
);
  localparam int unsigned ADDR_W = idx_w(NUM_REGS);

  logic                     rd_req;
  logic [NUM_RP*ADDR_W-1:0] rs_idx;
  logic                     rsv_flag;
  logic [ADDR_W-1:0]        rsv_idx;
  logic                     wb_flag;
  logic [ADDR_W-1:0]        wb_idx;
  logic [LEN-1:0]           wb_data;
  logic                     flush;
  logic                     reg_stall;
  logic                     rs_valid;
  logic [NUM_RP*LEN-1:0]    rs_data;

  modport master (
    output rd_req, rs_idx, rsv_flag, rsv_idx, wb_flag, wb_idx, wb_data, flush,
    input  reg_stall, rs_valid, rs_data
  );

  modport slave (
    input  rd_req, rs_idx, rsv_flag, rsv_idx, wb_flag, wb_idx, wb_data, flush,
    output reg_stall, rs_valid, rs_data
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// reg_scoreboard: per-register busy bits with RAW hazard detection.
//   clk, rst     - clock, async active-low reset
//   rdy_in       - global enable, 0 freezes the busy vector
//   flush        - clears every busy bit
//   set_en/idx   - reservation of an accepted request
//   wb_flag/idx  - write-back, clears busy and masks the hazard (bypass)
//   rs_idx       - packed source indices of all read ports
//   hazard       - some source port reads a busy, non-bypassed register
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter  int unsigned NUM_REGS = 32,
  parameter  int unsigned NUM_RP   = 2,
  localparam int unsigned ADDR_W   = idx_w(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy_in,
  input  logic                     flush,
  input  logic                     set_en,
  input  logic [ADDR_W-1:0]        set_idx,
  input  logic                     wb_flag,
  input  logic [ADDR_W-1:0]        wb_idx,
  input  logic [NUM_RP*ADDR_W-1:0] rs_idx,
  output logic                     hazard
);

  logic [NUM_REGS-1:0] busy_q, busy_d;

  always_comb begin
    logic [ADDR_W-1:0] src;
    hazard = 1'b0;
    src    = '0;
    for (int unsigned p = 0; p < NUM_RP; p++) begin
      src = rs_idx[slice_lo(p, ADDR_W) +: ADDR_W];
      if (src != ADDR_W'(ZERO_IDX) && busy_q[src] && !(wb_flag && wb_idx == src))
        hazard = 1'b1;
    end
  end

  // Clear before set so a re-reservation of the register being written back stays busy.
  always_comb begin
    busy_d = busy_q;
    if (rdy_in) begin
      if (flush) begin
        busy_d = '0;
      end else begin
        if (wb_flag)
          busy_d[wb_idx] = 1'b0;
        if (set_en && set_idx != ADDR_W'(ZERO_IDX))
          busy_d[set_idx] = 1'b1;
      end
    end
    busy_d[ZERO_IDX] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_d;
  end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-read-port integer register file with embedded scoreboard.
//   clk    - clock, rising edge
//   rst    - asynchronous reset, active-low
//   rdy_in - global enable, 0 freezes all state
//   bus    - reg_file_sb_if.slave: read request/reserve from decode, write-back,
//            flush; returns reg_stall (combinational), rs_valid/rs_data (registered,
//            latency 1). x0 reads as zero; same-cycle write-back is bypassed.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter  int unsigned LEN      = 32,
  parameter  int unsigned NUM_REGS = 32,
  parameter  int unsigned NUM_RP   = 2,
  localparam int unsigned ADDR_W   = idx_w(NUM_REGS)
) (
  input logic         clk,
  input logic         rst,
  input logic         rdy_in,
  reg_file_sb_if.slave bus
);

  logic [LEN-1:0]        regs_q [NUM_REGS];
  logic [LEN-1:0]        regs_d [NUM_REGS];
  logic                  rs_valid_q, rs_valid_d;
  logic [NUM_RP*LEN-1:0] rs_data_q, rs_data_d;
  logic [NUM_RP*LEN-1:0] rd_val;
  logic                  hazard;
  logic                  req_live;
  logic                  accept;

  assign req_live      = rdy_in && bus.rd_req && !bus.flush;
  assign bus.reg_stall = req_live && hazard;
  assign accept        = req_live && !hazard;

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .NUM_RP   (NUM_RP)
  ) u_scoreboard (
    .clk     (clk),
    .rst     (rst),
    .rdy_in  (rdy_in),
    .flush   (bus.flush),
    .set_en  (accept && bus.rsv_flag),
    .set_idx (bus.rsv_idx),
    .wb_flag (bus.wb_flag),
    .wb_idx  (bus.wb_idx),
    .rs_idx  (bus.rs_idx),
    .hazard  (hazard)
  );

  always_comb begin
    logic [ADDR_W-1:0] src;
    rd_val = '0;
    src    = '0;
    for (int unsigned p = 0; p < NUM_RP; p++) begin
      src = bus.rs_idx[slice_lo(p, ADDR_W) +: ADDR_W];
      if (src == ADDR_W'(ZERO_IDX))
        rd_val[slice_lo(p, LEN) +: LEN] = '0;
      else if (bus.wb_flag && bus.wb_idx == src)
        rd_val[slice_lo(p, LEN) +: LEN] = bus.wb_data;
      else
        rd_val[slice_lo(p, LEN) +: LEN] = regs_q[src];
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (rdy_in && bus.wb_flag && bus.wb_idx != ADDR_W'(ZERO_IDX))
      regs_d[bus.wb_idx] = bus.wb_data;
  end

  assign rs_valid_d = rdy_in ? accept : rs_valid_q;
  assign rs_data_d  = accept ? rd_val : rs_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++)
        regs_q[i] <= '0;
      rs_valid_q <= 1'b0;
      rs_data_q  <= '0;
    end else begin
      regs_q     <= regs_d;
      rs_valid_q <= rs_valid_d;
      rs_data_q  <= rs_data_d;
    end
  end

  assign bus.rs_valid = rs_valid_q;
  assign bus.rs_data  = rs_data_q;

endmodule
